// File: rtl/lock_supervisor.sv
// Lock supervisor: watches the lock FSM's unlock/error flags, counts consecutive
// failed attempts, drives a timed door release, and enforces a timed lockout
// during which the keypad code bit is forced high.
module lock_supervisor #(
  parameter int MAX_FAIL       = 3,
  parameter int OPEN_CYCLES    = 8,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       x_in,
  input  logic       ready,
  input  logic       unlock,
  input  logic       error,
  output logic       x_out,
  output logic       door_open,
  output logic       lockout,
  output logic       alarm,
  output logic [2:0] fail_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  localparam logic [3:0] FAIL_LIMIT = 4'(MAX_FAIL);
  localparam logic [2:0] FAIL_SAT   = 3'(MAX_FAIL);
  localparam logic [7:0] OPEN_LOAD  = 8'(OPEN_CYCLES - 1);
  localparam logic [7:0] LOCK_LOAD  = 8'(LOCKOUT_CYCLES - 1);

  state_t     state, state_nx;
  logic [7:0] timer, timer_nx;
  logic [2:0] fail_nx;
  logic       alarm_nx;
  logic       door_nx;
  logic       lock_nx;
  logic       unlock_d, error_d;
  logic       unlock_ev, error_ev;

  // ready is only a monitoring hookup; it has no functional effect
  logic       ready_unused;
  assign ready_unused = ready;

  assign unlock_ev = unlock & ~unlock_d;
  assign error_ev  = error & ~error_d;

  // Lockout pins the lock FSM in its error state by holding its x input high
  assign x_out = lockout ? 1'b1 : x_in;

  // Delayed copies of the flags; cleared by reset so a flag already high at
  // release is seen as a rising edge on the first clock
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      unlock_d <= 1'b0;
      error_d  <= 1'b0;
    end else begin
      unlock_d <= unlock;
      error_d  <= error;
    end
  end

  // State, shared timer and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      timer      <= 8'd0;
      fail_count <= 3'd0;
      door_open  <= 1'b0;
      lockout    <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      fail_count <= fail_nx;
      door_open  <= door_nx;
      lockout    <= lock_nx;
      alarm      <= alarm_nx;
    end
  end

  // Next-state logic; error wins over unlock when both rise in IDLE, and
  // both are ignored while a timed state is running
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    fail_nx  = fail_count;
    alarm_nx = 1'b0;
    case (state)
      IDLE: begin
        if (error_ev) begin
          if (({1'b0, fail_count} + 4'd1) >= FAIL_LIMIT) begin
            state_nx = LOCKOUT;
            timer_nx = LOCK_LOAD;
            fail_nx  = FAIL_SAT;
            alarm_nx = 1'b1;
          end else begin
            fail_nx = fail_count + 3'd1;
          end
        end else if (unlock_ev) begin
          state_nx = OPEN;
          timer_nx = OPEN_LOAD;
          fail_nx  = 3'd0;
        end
      end
      OPEN: begin
        if (timer == 8'd0) begin
          state_nx = IDLE;
        end else begin
          timer_nx = timer - 8'd1;
        end
      end
      LOCKOUT: begin
        if (timer == 8'd0) begin
          state_nx = IDLE;
          fail_nx  = 3'd0;
        end else begin
          timer_nx = timer - 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = 8'd0;
        fail_nx  = 3'd0;
      end
    endcase
    door_nx = (state_nx == OPEN);
    lock_nx = (state_nx == LOCKOUT);
  end

endmodule
